// File: rtl/regfile_pkg.sv
// regfile_pkg: reset-image encodings and reset-value helper for regfile_bypass_sb
package regfile_pkg;
  localparam int RST_ZERO  = 0;
  localparam int RST_INDEX = 1;
  function automatic logic [31:0] rf_reset_value(input int index, input int width);
    return width >= 32 ? 32'(index) : 32'(index) & ((32'd1 << width) - 32'd1);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits plus an incrementally kept busy count
// ports: set_en/set_addr reserve, clr_en/clr_addr retire, busy vector and busy_cnt out
module rf_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic inc, dec;
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    inc = set_en && !busy_q[set_addr];
    // a same-address reservation keeps the bit set, so the retire does not count
    dec = clr_en && busy_q[clr_addr] && !(set_en && set_addr == clr_addr);
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign busy     = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: parametrised register file with write bypass, zero register and busy scoreboard
// ports: wr_* writeback, rsv_* reservation, rd_addrN/rd_dataN/rd_readyN read ports, busy_cnt
module regfile_bypass_sb import regfile_pkg::*; #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 16,
  localparam int ADDR_W     = $clog2(NUM_REGS),
  parameter int RESET_IMAGE = 1,
  parameter int ZERO_REG    = 0,
  parameter int BYPASS      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_ready1,
  output logic              rd_ready2,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] rst_img [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic wr_ok, rsv_ok, hit1, hit2, z1, z2;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_img
    assign rst_img[i] = RESET_IMAGE == RST_INDEX ? DATA_W'(rf_reset_value(i, DATA_W)) : '0;
  end
  assign wr_ok  = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  // bypass is suppressed while reset is held so reads show the reset image
  assign hit1 = BYPASS != 0 && rst_n && wr_en && wr_addr == rd_addr1;
  assign hit2 = BYPASS != 0 && rst_n && wr_en && wr_addr == rd_addr2;
  assign z1   = ZERO_REG != 0 && rd_addr1 == '0;
  assign z2   = ZERO_REG != 0 && rd_addr2 == '0;
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= rst_img;
    else mem_q <= mem_d;
  end
  assign rd_data1  = z1 ? '0 : hit1 ? wr_data : mem_q[rd_addr1];
  assign rd_data2  = z2 ? '0 : hit2 ? wr_data : mem_q[rd_addr2];
  assign rd_ready1 = !busy[rd_addr1] || hit1;
  assign rd_ready2 = !busy[rd_addr2] || hit2;
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (rsv_ok),
    .set_addr (rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed checks of default, no-bypass and zero-register variants
module tb_regfile_bypass_sb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, rsv_en = 1'b0;
  logic [3:0] wr_addr = '0, rsv_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] d1_0, d2_0, d1_1, d2_1, d1_2, d2_2;
  logic r1_0, r2_0, r1_1, r2_1, r1_2, r2_2;
  logic [4:0] cnt_0, cnt_1, cnt_2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  regfile_bypass_sb u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_0), .rd_data2(d2_0), .rd_ready1(r1_0), .rd_ready2(r2_0), .busy_cnt(cnt_0)
  );
  regfile_bypass_sb #(.BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_1), .rd_data2(d2_1), .rd_ready1(r1_1), .rd_ready2(r2_1), .busy_cnt(cnt_1)
  );
  regfile_bypass_sb #(.ZERO_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_2), .rd_data2(d2_2), .rd_ready1(r1_2), .rd_ready2(r2_2), .busy_cnt(cnt_2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rd_addr1 = 4'd5;
    #12;
    chk("rst_held_data", d1_0, 32'h5);
    chk("rst_held_ready", r1_0, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd_addr1 = 4'd5; rd_addr2 = 4'd15; #1;
    chk("reset_d1", d1_0, 32'h0005);
    chk("reset_d2", d2_0, 32'h000F);
    chk("reset_r1", r1_0, 32'h1);
    chk("reset_r2", r2_0, 32'h1);
    chk("reset_cnt", cnt_0, 32'h0);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr1 = 4'd3; #1;
    chk("bypass_same", d1_0, 32'hBEEF);
    chk("nobypass_same", d1_1, 32'h0003);
    tick();
    wr_en = 1'b0; #1;
    chk("nobypass_next", d1_1, 32'hBEEF);
    chk("bypass_next", d1_0, 32'hBEEF);
    rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr1 = 4'd7; #1;
    chk("rsv_same_ready", r1_0, 32'h1);
    tick();
    rsv_en = 1'b0; #1;
    chk("rsv_busy_ready", r1_0, 32'h0);
    chk("rsv_cnt", cnt_0, 32'h1);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234; #1;
    chk("wb_bypass_ready", r1_0, 32'h1);
    chk("wb_bypass_data", d1_0, 32'h1234);
    chk("wb_nobypass_ready", r1_1, 32'h0);
    tick();
    wr_en = 1'b0; #1;
    chk("wb_cnt", cnt_0, 32'h0);
    chk("wb_data", d1_0, 32'h1234);
    chk("wb_ready", r1_0, 32'h1);
    rsv_en = 1'b1; rsv_addr = 4'd4;
    tick();
    #1;
    chk("coll_pre_cnt", cnt_0, 32'h1);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hAAAA;
    tick();
    rsv_en = 1'b0; wr_en = 1'b0; rd_addr1 = 4'd4; #1;
    chk("coll_data", d1_0, 32'hAAAA);
    chk("coll_busy", r1_0, 32'h0);
    chk("coll_cnt", cnt_0, 32'h1);
    rsv_en = 1'b1; rsv_addr = 4'd6; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0BAD;
    tick();
    rsv_en = 1'b0; wr_en = 1'b0; rd_addr2 = 4'd6; #1;
    chk("diff_cnt", cnt_0, 32'h1);
    chk("diff_r4", r1_0, 32'h1);
    chk("diff_r6", r2_0, 32'h0);
    chk("diff_d4", d1_0, 32'h0BAD);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h6666;
    tick();
    wr_en = 1'b0; #1;
    chk("idle_cnt", cnt_0, 32'h0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr1 = 4'd0; #1;
    chk("zero_same_data", d1_2, 32'h0);
    chk("zero_same_ready", r1_2, 32'h1);
    chk("nozero_same_data", d1_0, 32'hFFFF);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0; #1;
    chk("zero_data", d1_2, 32'h0);
    chk("zero_ready", r1_2, 32'h1);
    chk("zero_cnt", cnt_2, 32'h0);
    chk("nozero_data", d1_0, 32'hFFFF);
    chk("nozero_cnt", cnt_0, 32'h1);
    rsv_en = 1'b1; rsv_addr = 4'd2;
    tick();
    rsv_addr = 4'd9;
    tick();
    rsv_addr = 4'd11;
    tick();
    rsv_en = 1'b0; #1;
    chk("mid_cnt", cnt_0, 32'h4);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
    tick();
    wr_en = 1'b0; rd_addr1 = 4'd2; rd_addr2 = 4'd9; #1;
    chk("mid_wb_cnt", cnt_0, 32'h3);
    chk("mid_wb_data", d1_0, 32'h5555);
    chk("mid_r9", r2_0, 32'h0);
    rst_n = 1'b0; #1;
    chk("arst_cnt", cnt_0, 32'h0);
    chk("arst_d2", d1_0, 32'h0002);
    chk("arst_r2", r1_0, 32'h1);
    chk("arst_r9", r2_0, 32'h1);
    chk("arst_cnt_nb", cnt_1, 32'h0);
    rd_addr1 = 4'd0; #1;
    chk("arst_d0", d1_0, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd_addr1 = 4'd11; #1;
    chk("post_rst_r11", r1_0, 32'h1);
    chk("post_rst_cnt", cnt_0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
